// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// The relock counter width is used only when PLL_SUP_STATUS_EN is defined.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT,
    STABLE,
    RUN,
    FAIL
  } sup_state_t;

  localparam int RELOCK_W = 8;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchroniser that brings the PLL lock flag into the reference clock domain.
module pll_sup_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout and retry,
// qualifies lock stability, then releases the core reset. Re-sequences on loss of lock.
// Build option: define PLL_SUP_STATUS_EN to add the saturating relock_cnt status output.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int LOSS_FILTER   = 4
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic force_relock,
  output logic pll_rst,
  output logic core_rst_n,
  output logic ready,
  output logic fail
`ifdef PLL_SUP_STATUS_EN
  ,
  output logic [RELOCK_W-1:0] relock_cnt
`endif
);

  // One counter is reused for the hold, timeout and stability phases.
  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = cnt_w(CNT_MAX);
  localparam int RW        = cnt_w(MAX_RETRIES);
  localparam int LW        = cnt_w(LOSS_FILTER);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE   = RW'(1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_FILTER - 1);
  localparam logic [LW-1:0] LOSS_ONE    = LW'(1);

  logic            locked_s;
  sup_state_t      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   retry_reg;
  logic [LW-1:0]   loss_reg;
  logic            pll_rst_reg;
  logic            core_rst_n_reg;
  logic            ready_reg;
  logic            fail_reg;

  pll_sup_sync u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Sequencer: state, shared counter, retry/loss counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HOLD;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      loss_reg       <= '0;
      pll_rst_reg    <= 1'b1;
      core_rst_n_reg <= 1'b0;
      ready_reg      <= 1'b0;
      fail_reg       <= 1'b0;
    end else if (force_relock) begin
      // Full restart from any state, including a restart of an ongoing hold.
      state_reg      <= HOLD;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      loss_reg       <= '0;
      pll_rst_reg    <= 1'b1;
      core_rst_n_reg <= 1'b0;
      ready_reg      <= 1'b0;
      fail_reg       <= 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            state_reg   <= WAIT;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        WAIT: begin
          if (locked_s) begin
            // The first locked sample already counts toward stability.
            if (STABLE_LAST == '0) begin
              state_reg      <= RUN;
              cnt_reg        <= '0;
              retry_reg      <= '0;
              loss_reg       <= '0;
              core_rst_n_reg <= 1'b1;
              ready_reg      <= 1'b1;
            end else begin
              state_reg <= STABLE;
              cnt_reg   <= CNT_ONE;
            end
          end else if (cnt_reg == WAIT_LAST) begin
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            if (retry_reg < RETRY_MAX) begin
              state_reg <= HOLD;
              retry_reg <= retry_reg + RETRY_ONE;
            end else begin
              state_reg <= FAIL;
              fail_reg  <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            // A lock dropout is not a timeout: wait again without spending a retry.
            state_reg <= WAIT;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg      <= RUN;
            cnt_reg        <= '0;
            retry_reg      <= '0;
            loss_reg       <= '0;
            core_rst_n_reg <= 1'b1;
            ready_reg      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        RUN: begin
          if (locked_s) begin
            loss_reg <= '0;
          end else if (loss_reg == LOSS_LAST) begin
            state_reg      <= HOLD;
            cnt_reg        <= '0;
            loss_reg       <= '0;
            pll_rst_reg    <= 1'b1;
            core_rst_n_reg <= 1'b0;
            ready_reg      <= 1'b0;
          end else begin
            loss_reg <= loss_reg + LOSS_ONE;
          end
        end
        FAIL: begin
          pll_rst_reg    <= 1'b1;
          core_rst_n_reg <= 1'b0;
          fail_reg       <= 1'b1;
        end
        default: begin
          state_reg      <= HOLD;
          cnt_reg        <= '0;
          pll_rst_reg    <= 1'b1;
          core_rst_n_reg <= 1'b0;
          ready_reg      <= 1'b0;
          fail_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign core_rst_n = core_rst_n_reg;
  assign ready      = ready_reg;
  assign fail       = fail_reg;

`ifdef PLL_SUP_STATUS_EN
  localparam logic [RELOCK_W-1:0] RELOCK_ONE = RELOCK_W'(1);

  logic                loss_event;
  logic [RELOCK_W-1:0] relock_reg;

  assign loss_event = !force_relock && (state_reg == RUN) && !locked_s && (loss_reg == LOSS_LAST);

  // Saturating count of filtered loss-of-lock events; a forced relock leaves it alone.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      relock_reg <= '0;
    end else if (loss_event && (relock_reg != '1)) begin
      relock_reg <= relock_reg + RELOCK_ONE;
    end
  end

  assign relock_cnt = relock_reg;
`endif

endmodule
